// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 constants: register numbers, ExcCodes, Status/Cause bit positions
// and the exception priority encoder used by cp0_exc_ctrl.
package cp0_exc_ctrl_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;
  // ERET is not an architectural ExcCode; it only steers the flush/redirect path.
  localparam logic [4:0] EXC_ERET = 5'h1E;
  localparam logic [4:0] EXC_NONE = 5'h1F;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int CA_BD      = 31;
  localparam int CA_EXC_LO  = 2;
  localparam int CA_EXC_HI  = 6;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  function automatic logic [4:0] pick_exc(
    input logic int_pend, input logic fetch_adel, input logic ri,
    input logic ov, input logic sys, input logic brk, input logic eret,
    input logic adel, input logic ades);
    logic [4:0] code;
    if (int_pend)        code = EXC_INT;
    else if (fetch_adel) code = EXC_ADEL;
    else if (ri)         code = EXC_RI;
    else if (ov)         code = EXC_OV;
    else if (sys)        code = EXC_SYS;
    else if (brk)        code = EXC_BP;
    else if (eret)       code = EXC_ERET;
    else if (adel)       code = EXC_ADEL;
    else if (ades)       code = EXC_ADES;
    else                 code = EXC_NONE;
    return code;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// cp0_timer: Count/Compare pair. Count advances every second cycle; timer_int
// latches on a Count==Compare match and is cleared only by a Compare write.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d, compare_q, compare_d;
  logic        tint_q, tint_d;
  logic        count_upd;

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q;
    compare_d = compare_q;
    tint_d    = tint_q;
    count_upd = 1'b0;
    // A software write to Count takes precedence over the tick increment.
    if (count_we_i) begin
      count_d   = wdata_i;
      count_upd = 1'b1;
    end else if (tick_q) begin
      count_d   = count_q + 32'd1;
      count_upd = 1'b1;
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      tint_d    = 1'b0;
    end else if (count_upd && (count_d == compare_q)) begin
      tint_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      tint_q    <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      tint_q    <= tint_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = tint_q;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// MEM-stage exception responder and CP0 register file (Status/Cause/EPC/BadVAddr).
// Define CP0_TIMER_EN to add the Count/Compare timer (cp0_timer) and its interrupt.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_i,
  input  logic        valid_m_i,
  input  logic [31:0] pc_m_i,
  input  logic        in_delayslot_i,
  input  logic        adel_m_i,
  input  logic        ades_m_i,
  input  logic [31:0] bad_addr_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        eret_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] rdata_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic [4:0]  exccode_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic        timer_int_o
);

  logic [31:0] status_q, status_d, cause_q, cause_d;
  logic [31:0] epc_q, epc_d, badv_q, badv_d;
  logic [31:0] count, compare;
  logic        int_pend, fetch_adel, exc_take, eret_take, wr_en;
  logic [4:0]  code;

  assign int_pend   = status_q[ST_IE] & ~status_q[ST_EXL] & (|(cause_q[15:8] & status_q[15:8]));
  assign fetch_adel = (pc_m_i[1:0] != 2'b00);
  assign code       = valid_m_i ? pick_exc(int_pend, fetch_adel, ri_i, ov_i, syscall_i,
                                           break_i, eret_i, adel_m_i, ades_m_i)
                                : EXC_NONE;
  assign eret_take  = (code == EXC_ERET);
  assign exc_take   = (code != EXC_NONE) && !eret_take;
  assign flush_o    = exc_take | eret_take;
  assign newpc_o    = eret_take ? epc_q : EXC_VECTOR;
  assign exccode_o  = code;
  // An MTC0 in a flushed cycle belongs to a squashed instruction.
  assign wr_en      = we_i & ~flush_o;

`ifdef CP0_TIMER_EN
  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (wr_en && (waddr_i == CP0_COUNT)),
    .compare_we_i (wr_en && (waddr_i == CP0_COMPARE)),
    .wdata_i      (wdata_i),
    .count_o      (count),
    .compare_o    (compare),
    .timer_int_o  (timer_int_o)
  );
`else
  assign count       = 32'd0;
  assign compare     = 32'd0;
  assign timer_int_o = 1'b0;
`endif

  always_comb begin
    status_d = status_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    badv_d   = badv_q;
    cause_d[15:10] = {int_i[5] | timer_int_o, int_i[4:0]};
    if (exc_take) begin
      if (!status_q[ST_EXL]) begin
        epc_d          = in_delayslot_i ? (pc_m_i - 32'd4) : pc_m_i;
        cause_d[CA_BD] = in_delayslot_i;
      end
      status_d[ST_EXL]                = 1'b1;
      cause_d[CA_EXC_HI:CA_EXC_LO]    = code;
      // ExcCode 4 with a misaligned PC can only mean the fetch check won.
      if ((code == EXC_ADEL) && fetch_adel)            badv_d = pc_m_i;
      else if ((code == EXC_ADEL) || (code == EXC_ADES)) badv_d = bad_addr_i;
    end else if (eret_take) begin
      status_d[ST_EXL] = 1'b0;
    end else if (wr_en) begin
      case (waddr_i)
        CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
        CP0_CAUSE:  cause_d[9:8] = wdata_i[9:8];
        CP0_EPC:    epc_d = wdata_i;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= STATUS_RST;
      cause_q  <= 32'd0;
      epc_q    <= 32'd0;
      badv_q   <= 32'd0;
    end else begin
      status_q <= status_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      badv_q   <= badv_d;
    end
  end

  always_comb begin
    case (raddr_i)
      CP0_BADVADDR: rdata_o = badv_q;
      CP0_COUNT:    rdata_o = count;
      CP0_COMPARE:  rdata_o = compare;
      CP0_STATUS:   rdata_o = status_q;
      CP0_CAUSE:    rdata_o = cause_q;
      CP0_EPC:      rdata_o = epc_q;
      default:      rdata_o = 32'd0;
    endcase
  end

  assign status_o = status_q;
  assign cause_o  = cause_q;
  assign epc_o    = epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: field-level CP0 reference model, directed scenarios
// and a randomized run. Build with CP0_TIMER_EN to also exercise the timer.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        valid_m_i, in_delayslot_i, adel_m_i, ades_m_i;
  logic [31:0] pc_m_i, bad_addr_i, wdata_i;
  logic        syscall_i, break_i, eret_i, ri_i, ov_i, we_i;
  logic [4:0]  waddr_i, raddr_i;
  logic [31:0] rdata_o, newpc_o, status_o, cause_o, epc_o;
  logic        flush_o, timer_int_o;
  logic [4:0]  exccode_o;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .int_i(int_i), .valid_m_i(valid_m_i), .pc_m_i(pc_m_i),
    .in_delayslot_i(in_delayslot_i), .adel_m_i(adel_m_i), .ades_m_i(ades_m_i),
    .bad_addr_i(bad_addr_i), .syscall_i(syscall_i), .break_i(break_i),
    .eret_i(eret_i), .ri_i(ri_i), .ov_i(ov_i), .we_i(we_i), .waddr_i(waddr_i),
    .wdata_i(wdata_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .flush_o(flush_o),
    .newpc_o(newpc_o), .exccode_o(exccode_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .timer_int_o(timer_int_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model kept as separate architectural fields.
  bit          m_ie, m_exl, m_bd, m_tint, m_tick;
  bit [7:0]    m_im, m_ip;
  bit [4:0]    m_exc;
  bit [31:0]   m_epc, m_bad, m_cnt, m_cmp;
  // kind: 0 none, 1 exception, 2 eret; src of BadVAddr: 0 keep, 1 pc, 2 bad_addr
  int          e_kind, e_src;
  bit [4:0]    e_code;

  function automatic bit [31:0] m_status();
    return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
  endfunction

  function automatic bit [31:0] m_cause();
    return {m_bd, 15'd0, m_ip, 1'b0, m_exc, 2'b00};
  endfunction

  task automatic model_reset();
    m_ie = 0; m_exl = 0; m_bd = 0; m_tint = 0; m_tick = 0;
    m_im = 0; m_ip = 0; m_exc = 0; m_epc = 0; m_bad = 0; m_cnt = 0; m_cmp = 0;
  endtask

  task automatic model_comb();
    bit pend;
    pend = m_ie && !m_exl && ((m_ip & m_im) != 8'd0);
    e_kind = 1; e_src = 0; e_code = 5'h1F;
    if (!valid_m_i)                e_kind = 0;
    else if (pend)                 e_code = 5'h00;
    else if (pc_m_i[1:0] != 2'b00) begin e_code = 5'h04; e_src = 1; end
    else if (ri_i)                 e_code = 5'h0A;
    else if (ov_i)                 e_code = 5'h0C;
    else if (syscall_i)            e_code = 5'h08;
    else if (break_i)              e_code = 5'h09;
    else if (eret_i)               e_kind = 2;
    else if (adel_m_i)             begin e_code = 5'h04; e_src = 2; end
    else if (ades_m_i)             begin e_code = 5'h05; e_src = 2; end
    else                           e_kind = 0;
  endtask

  function automatic bit [31:0] m_read(input bit [4:0] a);
    case (a)
      5'd8:  return m_bad;
      5'd9:  return m_cnt;
      5'd11: return m_cmp;
      5'd12: return m_status();
      5'd13: return m_cause();
      5'd14: return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clock();
    bit [7:0] ip_n;
    bit wr, upd;
    ip_n = {int_i[5] | m_tint, int_i[4:0], m_ip[1:0]};
    wr = we_i && (e_kind == 0);
    if (e_kind == 1) begin
      if (!m_exl) begin
        m_epc = in_delayslot_i ? pc_m_i - 32'd4 : pc_m_i;
        m_bd  = in_delayslot_i;
      end
      m_exl = 1; m_exc = e_code;
      if (e_src == 1) m_bad = pc_m_i;
      else if (e_src == 2) m_bad = bad_addr_i;
    end else if (e_kind == 2) begin
      m_exl = 0;
    end else if (wr) begin
      case (waddr_i)
        5'd12: begin m_im = wdata_i[15:8]; m_exl = wdata_i[1]; m_ie = wdata_i[0]; end
        5'd13: ip_n[1:0] = wdata_i[9:8];
        5'd14: m_epc = wdata_i;
        default: ;
      endcase
    end
    m_ip = ip_n;
`ifdef CP0_TIMER_EN
    upd = 0;
    if (wr && waddr_i == 5'd9) begin m_cnt = wdata_i; upd = 1; end
    else if (m_tick)            begin m_cnt = m_cnt + 1; upd = 1; end
    if (wr && waddr_i == 5'd11) begin m_cmp = wdata_i; m_tint = 0; end
    else if (upd && m_cnt == m_cmp) m_tint = 1;
    m_tick = !m_tick;
`else
    upd = 0;
`endif
  endtask

  // Inputs are set at the falling edge; compare, clock the model, return to the next fall.
  task automatic step();
    #1;
    model_comb();
    check("flush", {31'd0, flush_o}, {31'd0, e_kind != 0});
    if (e_kind != 0) check("newpc", newpc_o, (e_kind == 2) ? m_epc : 32'hBFC0_0380);
    if (e_kind != 2) check("exccode", {27'd0, exccode_o}, {27'd0, e_code});
    check("rdata", rdata_o, m_read(raddr_i));
    check("status", status_o, m_status());
    check("cause", cause_o, m_cause());
    check("epc", epc_o, m_epc);
    check("timer_int", {31'd0, timer_int_o}, {31'd0, m_tint});
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    int_i = 0; valid_m_i = 0; pc_m_i = 32'hBFC0_0000; in_delayslot_i = 0;
    adel_m_i = 0; ades_m_i = 0; bad_addr_i = 0; syscall_i = 0; break_i = 0;
    eret_i = 0; ri_i = 0; ov_i = 0; we_i = 0; waddr_i = 0; wdata_i = 0; raddr_i = 0;
  endtask

  task automatic mtc0(input bit [4:0] a, input bit [31:0] d);
    idle(); we_i = 1; waddr_i = a; wdata_i = d; step(); idle();
  endtask

  task automatic do_eret();
    idle(); valid_m_i = 1; eret_i = 1; step(); idle();
  endtask

  int cyc;

  initial begin
    idle();
    rst = 1;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'd0);
    check("rst_epc", epc_o, 32'd0);
    check("rst_timer", {31'd0, timer_int_o}, 32'd0);
    @(negedge clk);
    rst = 0;

    // Load address error.
    valid_m_i = 1; adel_m_i = 1; bad_addr_i = 32'h8000_0002; pc_m_i = 32'hBFC0_0100;
    #1;
    check("adel_flush", {31'd0, flush_o}, 32'd1);
    check("adel_newpc", newpc_o, 32'hBFC0_0380);
    step();
    idle(); raddr_i = 5'd8;
    #1;
    check("adel_epc", epc_o, 32'hBFC0_0100);
    check("adel_badv", rdata_o, 32'h8000_0002);
    check("adel_code", {27'd0, cause_o[6:2]}, 32'd4);
    check("adel_exl", {31'd0, status_o[1]}, 32'd1);
    step();

    // Store address error in a delay slot.
    do_eret();
    valid_m_i = 1; ades_m_i = 1; in_delayslot_i = 1; pc_m_i = 32'hBFC0_0204;
    bad_addr_i = 32'h1000_0001;
    step();
    idle();
    #1;
    check("ades_epc", epc_o, 32'hBFC0_0200);
    check("ades_bd", {31'd0, cause_o[31]}, 32'd1);
    check("ades_code", {27'd0, cause_o[6:2]}, 32'd5);

    // Syscall outranks the store error; BadVAddr keeps the previous fault.
    do_eret();
    valid_m_i = 1; syscall_i = 1; ades_m_i = 1; pc_m_i = 32'hBFC0_0300;
    bad_addr_i = 32'h2222_0003; raddr_i = 5'd8;
    step();
    idle(); raddr_i = 5'd8;
    #1;
    check("sys_code", {27'd0, cause_o[6:2]}, 32'd8);
    check("sys_badv", rdata_o, 32'h1000_0001);
    valid_m_i = 1; eret_i = 1;
    #1;
    check("eret_newpc", newpc_o, 32'hBFC0_0300);
    step();
    idle();
    #1;
    check("eret_exl", {31'd0, status_o[1]}, 32'd0);

    // Nested exception while EXL is set, then a bubble carrying flags.
    valid_m_i = 1; break_i = 1; pc_m_i = 32'hBFC0_0400; in_delayslot_i = 1;
    step();
    idle(); valid_m_i = 1; ri_i = 1; pc_m_i = 32'hBFC0_0500;
    step();
    idle();
    #1;
    check("nest_epc", epc_o, 32'hBFC0_03FC);
    check("nest_bd", {31'd0, cause_o[31]}, 32'd1);
    check("nest_code", {27'd0, cause_o[6:2]}, 32'h0A);
    valid_m_i = 0; syscall_i = 1; adel_m_i = 1; eret_i = 1; pc_m_i = 32'hBFC0_0601;
    #1;
    check("bubble_flush", {31'd0, flush_o}, 32'd0);
    step();

    // Interrupt via IM2/IE, same-cycle MTC0 to EPC is dropped.
    do_eret();
    idle(); int_i = 6'b000001; we_i = 1; waddr_i = 5'd12; wdata_i = 32'h0000_0401;
    step();
    idle(); int_i = 6'b000001; valid_m_i = 1; pc_m_i = 32'hBFC0_0700;
    we_i = 1; waddr_i = 5'd14; wdata_i = 32'hDEAD_BEE0;
    #1;
    check("int_flush", {31'd0, flush_o}, 32'd1);
    check("int_code_o", {27'd0, exccode_o}, 32'd0);
    step();
    idle();
    #1;
    check("int_epc", epc_o, 32'hBFC0_0700);
    check("int_code", {27'd0, cause_o[6:2]}, 32'd0);
    do_eret();
    mtc0(5'd12, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      idle();
      int_i          = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
      valid_m_i      = $urandom_range(0, 3) != 0;
      pc_m_i         = {$urandom_range(0, 65535) + 32'hBFC0_0000, 2'b00} >> 2 << 2;
      if ($urandom_range(0, 11) == 0) pc_m_i[1:0] = 2'($urandom_range(1, 3));
      in_delayslot_i = $urandom_range(0, 3) == 0;
      adel_m_i       = $urandom_range(0, 11) == 0;
      ades_m_i       = $urandom_range(0, 11) == 0;
      bad_addr_i     = $urandom;
      syscall_i      = $urandom_range(0, 15) == 0;
      break_i        = $urandom_range(0, 15) == 0;
      eret_i         = $urandom_range(0, 5) == 0;
      ri_i           = $urandom_range(0, 15) == 0;
      ov_i           = $urandom_range(0, 15) == 0;
      we_i           = $urandom_range(0, 2) == 0;
      case ($urandom_range(0, 6))
        0: waddr_i = 5'd8;  1: waddr_i = 5'd9;  2: waddr_i = 5'd11;
        3: waddr_i = 5'd12; 4: waddr_i = 5'd13; 5: waddr_i = 5'd14;
        default: waddr_i = 5'($urandom);
      endcase
      wdata_i = $urandom;
      raddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(8, 14));
      step();
    end

`ifdef CP0_TIMER_EN
    // Compare=10, Count=0: match after roughly 20 cycles, cleared by Compare write.
    idle();
    mtc0(5'd11, 32'd10);
    mtc0(5'd9, 32'd0);
    cyc = 0;
    while (!timer_int_o && cyc < 40) begin
      raddr_i = 5'd9;
      step();
      cyc++;
    end
    check("timer_rise", {31'd0, timer_int_o}, 32'd1);
    check("timer_count", {27'd0, 5'($unsigned(cyc) > 32'd18 && $unsigned(cyc) < 32'd22)}, 32'd1);
    mtc0(5'd11, 32'd1000);
    #1;
    check("timer_clear", {31'd0, timer_int_o}, 32'd0);
    for (int i = 0; i < 5; i++) begin raddr_i = 5'd9; step(); end
`endif

    // Asynchronous reset mid-run.
    idle(); raddr_i = 5'd9;
    rst = 1;
    model_reset();
    #1;
    check("rst2_status", status_o, 32'h0040_0000);
    check("rst2_cause", cause_o, 32'd0);
    check("rst2_epc", epc_o, 32'd0);
    check("rst2_count", rdata_o, 32'd0);
    check("rst2_timer", {31'd0, timer_int_o}, 32'd0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 6; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
